poly_slot_engine: RTL and testbench

Parametrised successor to the single-core NTT slot engine. It is a polynomial slot memory with NUM_SLOTS banks of N coefficients each, served by a pipelined DMA port to the shared memory arbiter. The DMA port keeps up to MAX_OUTSTANDING reads in flight. The block also runs element-wise slot operations (COPY, modular ADD, modular SUB) and sits beside the NTT cores on the same arbiter.

---
 rtl/poly_slot_engine.sv | 231 +++++++++++++++++++++++
 tb/tb_poly_slot_engine.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_slot_engine.sv
// Polynomial slot memory (NUM_SLOTS x N coefficients) with pipelined DMA LOAD/STORE and
// element-wise COPY/ADD/SUB. Define POLY_SLOT_PERF_EN to build the arbiter stall counter.
module poly_slot_engine #(
    parameter int unsigned N_LOG           = 12,
    parameter int unsigned N               = 4096,
    parameter int unsigned NUM_SLOTS       = 8,
    parameter int unsigned SLOT_W          = 3,
    parameter int unsigned DATA_W          = 64,
    parameter int unsigned ADDR_W          = 48,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_opcode,
    input  logic [SLOT_W-1:0] cmd_slot_a,
    input  logic [SLOT_W-1:0] cmd_slot_b,
    input  logic [SLOT_W-1:0] cmd_slot_d,
    input  logic [ADDR_W-1:0] cmd_dma_addr,
    input  logic [DATA_W-1:0] q,
    output logic              done,
    output logic              err_illegal,
    output logic              arb_req,
    output logic              arb_we,
    output logic [ADDR_W-1:0] arb_addr,
    output logic [DATA_W-1:0] arb_wdata,
    input  logic              arb_gnt,
    input  logic              arb_valid,
    input  logic [DATA_W-1:0] arb_rdata,
    output logic [2:0]        dbg_state,
    output logic [63:0]       perf_counter_out
);
    localparam int unsigned IDX_W  = N_LOG + 1;
    localparam int unsigned MEM_AW = SLOT_W + N_LOG;
    localparam int unsigned BYTES  = DATA_W / 8;

    localparam logic [IDX_W-1:0] NIdx    = IDX_W'(N);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N - 1);
    localparam logic [3:0]       MaxOut  = 4'(MAX_OUTSTANDING);

    localparam logic [7:0] OpLoad  = 8'h02;
    localparam logic [7:0] OpStore = 8'h03;
    localparam logic [7:0] OpCopy  = 8'h05;
    localparam logic [7:0] OpAdd   = 8'h20;
    localparam logic [7:0] OpSub   = 8'h21;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StStore = 3'd2,
        StElem  = 3'd3,
        StDone  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        op_q, op_d;
    logic [SLOT_W-1:0] slot_a_q, slot_a_d, slot_b_q, slot_b_d, slot_d_q, slot_d_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [IDX_W-1:0]  req_idx_q, req_idx_d, ack_idx_q, ack_idx_d;
    logic [3:0]        outst_q, outst_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem [NUM_SLOTS*N];
    logic              mem_we;
    logic [MEM_AW-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W-1:0] op_a, op_b, elem_res;
    logic [DATA_W:0]   sum;
    logic [ADDR_W-1:0] elem_addr;
    logic              grant, rsp, legal;

    assign op_a      = mem[{slot_a_q, req_idx_q[N_LOG-1:0]}];
    assign op_b      = mem[{slot_b_q, req_idx_q[N_LOG-1:0]}];
    assign elem_addr = base_q + ADDR_W'(req_idx_q) * ADDR_W'(BYTES);
    assign grant     = arb_req & arb_gnt;
    // Responses outside LOAD, or beyond the last element, are dropped.
    assign rsp       = arb_valid && (state_q == StLoad) && (ack_idx_q < NIdx);
    assign legal     = (cmd_opcode == OpLoad) || (cmd_opcode == OpStore) ||
                       (cmd_opcode == OpCopy) || (cmd_opcode == OpAdd) || (cmd_opcode == OpSub);
    assign dbg_state   = state_q;
    assign err_illegal = err_q;

    always_comb begin
        sum = {1'b0, op_a} + {1'b0, op_b};
        case (op_q)
            OpAdd:   elem_res = (sum >= {1'b0, q}) ? DATA_W'(sum - {1'b0, q}) : sum[DATA_W-1:0];
            OpSub:   elem_res = (op_a >= op_b) ? op_a - op_b : op_a - op_b + q;
            default: elem_res = op_a;
        endcase
    end

    always_comb begin
        arb_req   = 1'b0;
        arb_we    = 1'b0;
        arb_addr  = '0;
        arb_wdata = '0;
        case (state_q)
            StLoad: begin
                arb_req  = (req_idx_q < NIdx) && (outst_q < MaxOut);
                arb_addr = elem_addr;
            end
            StStore: begin
                arb_req   = 1'b1;
                arb_we    = 1'b1;
                arb_addr  = elem_addr;
                arb_wdata = op_a;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        slot_a_d  = slot_a_q;
        slot_b_d  = slot_b_q;
        slot_d_d  = slot_d_q;
        base_d    = base_q;
        req_idx_d = req_idx_q;
        ack_idx_d = ack_idx_q;
        outst_d   = outst_q;
        err_d     = 1'b0;
        cmd_ready = 1'b0;
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = {slot_a_q, ack_idx_q[N_LOG-1:0]};
        mem_wdata = arb_rdata;
        case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (legal) begin
                        op_d      = cmd_opcode;
                        slot_a_d  = cmd_slot_a;
                        slot_b_d  = cmd_slot_b;
                        slot_d_d  = cmd_slot_d;
                        base_d    = cmd_dma_addr;
                        req_idx_d = '0;
                        ack_idx_d = '0;
                        outst_d   = '0;
                        if (cmd_opcode == OpLoad)       state_d = StLoad;
                        else if (cmd_opcode == OpStore) state_d = StStore;
                        else                            state_d = StElem;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (grant) req_idx_d = req_idx_q + 1'b1;
                if (rsp) begin
                    mem_we    = 1'b1;
                    ack_idx_d = ack_idx_q + 1'b1;
                    if (ack_idx_q == LastIdx) state_d = StDone;
                end
                if (grant && !rsp)      outst_d = outst_q + 4'd1;
                else if (!grant && rsp) outst_d = outst_q - 4'd1;
            end
            StStore: begin
                if (grant) begin
                    req_idx_d = req_idx_q + 1'b1;
                    if (req_idx_q == LastIdx) state_d = StDone;
                end
            end
            StElem: begin
                mem_we    = 1'b1;
                mem_waddr = {slot_d_q, req_idx_q[N_LOG-1:0]};
                mem_wdata = elem_res;
                req_idx_d = req_idx_q + 1'b1;
                if (req_idx_q == LastIdx) state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= '0;
            slot_a_q  <= '0;
            slot_b_q  <= '0;
            slot_d_q  <= '0;
            base_q    <= '0;
            req_idx_q <= '0;
            ack_idx_q <= '0;
            outst_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            slot_a_q  <= slot_a_d;
            slot_b_q  <= slot_b_d;
            slot_d_q  <= slot_d_d;
            base_q    <= base_d;
            req_idx_q <= req_idx_d;
            ack_idx_q <= ack_idx_d;
            outst_q   <= outst_d;
            err_q     <= err_d;
        end
    end

    // Slot contents survive reset; only the write is suppressed during it.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
    end

`ifdef POLY_SLOT_PERF_EN
    logic [63:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (arb_req && !arb_gnt && (perf_q != '1)) perf_d = perf_q + 64'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) perf_q <= '0;
        else     perf_q <= perf_d;
    end

    assign perf_counter_out = perf_q;
`else
    assign perf_counter_out = '0;
`endif

endmodule

// File: tb/tb_poly_slot_engine.sv
// Self-checking bench for poly_slot_engine: arbiter/memory model plus a slot-level reference
// model; random data and operands checked by reading slots back through STORE.
module tb_poly_slot_engine;
    localparam int N_LOG = 4;
    localparam int N     = 16;
    localparam int NS    = 8;

    localparam logic [7:0] OP_LOAD  = 8'h02;
    localparam logic [7:0] OP_STORE = 8'h03;
    localparam logic [7:0] OP_COPY  = 8'h05;
    localparam logic [7:0] OP_ADD   = 8'h20;
    localparam logic [7:0] OP_SUB   = 8'h21;

    logic        clk = 1'b0;
    logic        rst, cmd_valid, cmd_ready, done, err_illegal;
    logic [7:0]  cmd_opcode;
    logic [2:0]  cmd_slot_a, cmd_slot_b, cmd_slot_d, dbg_state;
    logic [47:0] cmd_dma_addr, arb_addr;
    logic [63:0] q, arb_wdata, arb_rdata, perf_counter_out;
    logic        arb_req, arb_we, arb_gnt, arb_valid;

    always #5 clk = ~clk;

    poly_slot_engine #(
        .N_LOG(N_LOG), .N(N), .NUM_SLOTS(NS), .SLOT_W(3), .DATA_W(64), .ADDR_W(48),
        .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_slot_a(cmd_slot_a), .cmd_slot_b(cmd_slot_b),
        .cmd_slot_d(cmd_slot_d), .cmd_dma_addr(cmd_dma_addr), .q(q), .done(done),
        .err_illegal(err_illegal), .arb_req(arb_req), .arb_we(arb_we), .arb_addr(arb_addr),
        .arb_wdata(arb_wdata), .arb_gnt(arb_gnt), .arb_valid(arb_valid),
        .arb_rdata(arb_rdata), .dbg_state(dbg_state), .perf_counter_out(perf_counter_out)
    );

    int tests = 0;
    int fails = 0;

    // Arbiter / external memory model state
    int          cyc = 0, gnt_mode = 0, lat = 3, gnt_budget = 0;
    logic [63:0] ext_mem [logic [47:0]];
    logic [63:0] rsp_data_q[$];
    int          rsp_due_q[$];
    logic [47:0] rd_addr_log[$], wr_addr_log[$];
    logic [63:0] wr_data_log[$];
    int          inflight = 0, max_inflight = 0, stall_cnt = 0, stab_viol = 0;
    logic        prev_wait = 1'b0;
    logic [47:0] prev_addr;
    logic [63:0] prev_wdata;

    logic [63:0] model [NS][N];
    logic [63:0] stage [N];

    function automatic logic [63:0] ext_rd(logic [47:0] a);
        if (ext_mem.exists(a)) return ext_mem[a];
        return {16'hdead, a};
    endfunction

    initial begin
        arb_gnt = 1'b0; arb_valid = 1'b0; arb_rdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            case (gnt_mode)
                0:       arb_gnt = 1'b1;
                1:       arb_gnt = (cyc % 3 == 0);
                2:       arb_gnt = ($urandom_range(0, 1) == 1);
                default: arb_gnt = (gnt_budget > 0);
            endcase
            if (rsp_due_q.size() > 0 && rsp_due_q[0] <= cyc) begin
                arb_valid = 1'b1;
                arb_rdata = rsp_data_q.pop_front();
                void'(rsp_due_q.pop_front());
                inflight--;
            end else begin
                arb_valid = 1'b0;
                arb_rdata = {$urandom, $urandom};
            end
            if (prev_wait && arb_req &&
                (arb_addr !== prev_addr || arb_wdata !== prev_wdata)) stab_viol++;
            prev_wait  = arb_req && !arb_gnt;
            prev_addr  = arb_addr;
            prev_wdata = arb_wdata;
            if (arb_req && !arb_gnt) stall_cnt++;
            if (arb_req && arb_gnt) begin
                if (gnt_mode == 3) gnt_budget--;
                if (arb_we) begin
                    wr_addr_log.push_back(arb_addr);
                    wr_data_log.push_back(arb_wdata);
                end else begin
                    rd_addr_log.push_back(arb_addr);
                    rsp_data_q.push_back(ext_rd(arb_addr));
                    rsp_due_q.push_back(cyc + lat);
                    inflight++;
                    if (inflight > max_inflight) max_inflight = inflight;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic issue(input logic [7:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] d, input logic [47:0] addr);
        @(negedge clk);
        rd_addr_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
        max_inflight = inflight;
        cmd_valid = 1'b1; cmd_opcode = op; cmd_slot_a = a; cmd_slot_b = b; cmd_slot_d = d;
        cmd_dma_addr = addr;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [7:0] op, input logic [2:0] a, input logic [2:0] b,
                           input logic [2:0] d, input logic [47:0] addr,
                           output int ndone, output bit tout, output bit rdy_after);
        issue(op, a, b, d, addr);
        ndone = 0; tout = 1'b1; rdy_after = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done) begin
                ndone++;
                @(negedge clk);
                rdy_after = cmd_ready && !done;
                tout = 1'b0;
                break;
            end
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
    endtask

    task automatic load_stage(input logic [2:0] slot, input logic [47:0] base,
                              output int ndone, output bit tout);
        bit r;
        for (int i = 0; i < N; i++) ext_mem[base + 48'(i * 8)] = stage[i];
        run_cmd(OP_LOAD, slot, 3'd0, 3'd0, base, ndone, tout, r);
        for (int i = 0; i < N; i++) model[slot][i] = stage[i];
    endtask

    function automatic logic [63:0] exp_perf();
`ifdef POLY_SLOT_PERF_EN
        return 64'(stall_cnt);
`else
        return 64'd0;
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_slot_a = '0; cmd_slot_b = '0;
        cmd_slot_d = '0; cmd_dma_addr = '0; q = 64'd97;
        repeat (3) @(negedge clk);
        tests++;
        if ({cmd_ready, done, err_illegal} !== 3'b100) begin
            fails++; $display("FAIL reset_ctl: got %b expected 100", {cmd_ready, done, err_illegal});
        end
        tests++;
        if ({arb_req, arb_we} !== 2'b00) begin
            fails++; $display("FAIL reset_arb: got %b expected 00", {arb_req, arb_we});
        end
        tests++;
        if (arb_addr !== 48'd0 || arb_wdata !== 64'd0) begin
            fails++; $display("FAIL reset_bus: addr %0h wdata %0h expected 0", arb_addr, arb_wdata);
        end
        tests++;
        if (dbg_state !== 3'd0) begin
            fails++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
        end
        tests++;
        if (perf_counter_out !== 64'd0) begin
            fails++; $display("FAIL reset_perf: got %0d expected 0", perf_counter_out);
        end
        rst = 1'b0;
        stall_cnt = 0;
        @(negedge clk);
    endtask

    task automatic test_load();
        int nd, bad; bit to;
        logic [47:0] base;
        gnt_mode = 0; lat = 3;
        for (int i = 0; i < N; i++) stage[i] = {$urandom, $urandom};
        load_stage(3'd2, 48'h1000, nd, to);
        tests++;
        if (to !== 1'b0 || nd != 1) begin
            fails++; $display("FAIL load_done: done pulses %0d timeout %0d expected 1/0", nd, to);
        end
        bad = 0;
        for (int i = 0; i < rd_addr_log.size(); i++)
            if (rd_addr_log[i] !== 48'h1000 + 48'(i * 8)) bad++;
        tests++;
        if (rd_addr_log.size() != N || bad != 0) begin
            fails++; $display("FAIL load_addr: %0d reads, %0d bad, expected %0d/0",
                              rd_addr_log.size(), bad, N);
        end
        tests++;
        if (max_inflight > 4) begin
            fails++; $display("FAIL load_inflight: got %0d expected <=4", max_inflight);
        end
        // Long latency hits the outstanding cap; base straddles the 48-bit wrap.
        lat = 8;
        base = 48'hFFFF_FFFF_FFC0;
        for (int i = 0; i < N; i++) stage[i] = {$urandom, $urandom};
        load_stage(3'd4, base, nd, to);
        tests++;
        if (to !== 1'b0 || nd != 1) begin
            fails++; $display("FAIL load_wrap_done: done %0d timeout %0d expected 1/0", nd, to);
        end
        tests++;
        if (max_inflight != 4) begin
            fails++; $display("FAIL load_cap: max in flight %0d expected 4", max_inflight);
        end
        bad = 0;
        for (int i = 0; i < rd_addr_log.size(); i++)
            if (rd_addr_log[i] !== base + 48'(i * 8)) bad++;
        tests++;
        if (rd_addr_log.size() != N || bad != 0) begin
            fails++; $display("FAIL load_wrap_addr: %0d reads, %0d bad", rd_addr_log.size(), bad);
        end
        lat = 3;
    endtask

    task automatic test_store();
        int nd, bad; bit to, rdy;
        logic [2:0] slot;
        logic [47:0] base;
        for (int k = 0; k < 2; k++) begin
            gnt_mode = (k == 0) ? 1 : 2;
            slot = (k == 0) ? 3'd2 : 3'd4;
            base = (k == 0) ? 48'h8000 : 48'h9000;
            stab_viol = 0;
            run_cmd(OP_STORE, slot, 3'd0, 3'd0, base, nd, to, rdy);
            tests++;
            if (to !== 1'b0 || nd != 1 || rdy !== 1'b1) begin
                fails++; $display("FAIL store_done[%0d]: done %0d timeout %0d ready %0d", k, nd,
                                  to, rdy);
            end
            bad = 0;
            for (int i = 0; i < wr_addr_log.size(); i++)
                if (wr_addr_log[i] !== base + 48'(i * 8) || wr_data_log[i] !== model[slot][i])
                    bad++;
            tests++;
            if (wr_addr_log.size() != N || bad != 0) begin
                fails++; $display("FAIL store_data[%0d]: %0d writes, %0d bad, expected %0d/0", k,
                                  wr_addr_log.size(), bad, N);
            end
            tests++;
            if (stab_viol != 0) begin
                fails++; $display("FAIL store_stable[%0d]: %0d changes while waiting", k, stab_viol);
            end
            tests++;
            if (perf_counter_out !== exp_perf()) begin
                fails++; $display("FAIL perf[%0d]: got %0d expected %0d", k, perf_counter_out,
                                  exp_perf());
            end
        end
        gnt_mode = 0;
    endtask

    // Runs one element op through the DUT and applies the arithmetic rule to the model.
    task automatic elem_op(input logic [7:0] op, input logic [2:0] a, input logic [2:0] b,
                           input logic [2:0] d);
        int nd; bit to, rdy;
        logic [64:0] x, y, m;
        run_cmd(op, a, b, d, 48'h0, nd, to, rdy);
        tests++;
        if (to !== 1'b0 || nd != 1) begin
            fails++; $display("FAIL elem_done op %0h: done %0d timeout %0d", op, nd, to);
        end
        m = {1'b0, q};
        for (int i = 0; i < N; i++) begin
            x = {1'b0, model[a][i]};
            y = {1'b0, model[b][i]};
            if (op == OP_ADD)      model[d][i] = 64'((x + y) % m);
            else if (op == OP_SUB) model[d][i] = 64'((x + m - y) % m);
            else                   model[d][i] = model[a][i];
        end
    endtask

    task automatic check_slots(input logic [2:0] s0, input logic [2:0] s1, input logic [2:0] s2,
                               input string tag);
        logic [2:0] sl [3];
        int nd, bad; bit to, rdy;
        sl[0] = s0; sl[1] = s1; sl[2] = s2;
        for (int k = 0; k < 3; k++) begin
            run_cmd(OP_STORE, sl[k], 3'd0, 3'd0, 48'h40000, nd, to, rdy);
            bad = 0;
            for (int i = 0; i < wr_data_log.size(); i++)
                if (wr_data_log[i] !== model[sl[k]][i]) bad++;
            tests++;
            if (wr_data_log.size() != N || bad != 0 || to) begin
                fails++; $display("FAIL %s slot %0d: %0d writes, %0d bad, e.g. got %0h exp %0h",
                                  tag, sl[k], wr_data_log.size(), bad,
                                  (wr_data_log.size() > 0) ? wr_data_log[0] : 64'hx,
                                  model[sl[k]][0]);
            end
        end
    endtask

    task automatic test_elem();
        int nd; bit to;
        q = 64'd97;
        for (int i = 0; i < N; i++) stage[i] = 64'd96;
        load_stage(3'd0, 48'h10000, nd, to);
        for (int i = 0; i < N; i++) stage[i] = 64'd5;
        load_stage(3'd1, 48'h11000, nd, to);
        elem_op(OP_ADD, 3'd0, 3'd1, 3'd0);
        elem_op(OP_COPY, 3'd0, 3'd0, 3'd5);
        tests++;
        if (model[5][7] !== 64'd4) begin
            fails++; $display("FAIL add_rule: model gives %0d expected 4", model[5][7]);
        end
        for (int i = 0; i < N; i++) stage[i] = 64'd3;
        load_stage(3'd0, 48'h12000, nd, to);
        for (int i = 0; i < N; i++) stage[i] = 64'd10;
        load_stage(3'd1, 48'h13000, nd, to);
        elem_op(OP_SUB, 3'd0, 3'd1, 3'd0);
        elem_op(OP_SUB, 3'd1, 3'd1, 3'd3);
        check_slots(3'd0, 3'd3, 3'd5, "elem_directed");
    endtask

    task automatic test_random_elem();
        int nd; bit to;
        for (int r = 0; r < 2; r++) begin
            q = (r == 0) ? {1'b1, 31'($urandom), $urandom} : 64'($urandom_range(2, 1000));
            for (int i = 0; i < N; i++) stage[i] = {$urandom, $urandom} % q;
            load_stage(3'd5, 48'h20000, nd, to);
            for (int i = 0; i < N; i++) stage[i] = {$urandom, $urandom} % q;
            load_stage(3'd6, 48'h21000, nd, to);
            elem_op(OP_ADD, 3'd5, 3'd6, 3'd7);
            elem_op(OP_SUB, 3'd7, 3'd6, 3'd6);
            elem_op(OP_SUB, 3'd5, 3'd7, 3'd5);
            check_slots(3'd5, 3'd6, 3'd7, "elem_random");
        end
        q = 64'd97;
    endtask

    task automatic test_illegal();
        int errs = 0, reqs = 0, busy = 0;
        logic err_first;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opcode = 8'h7F;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (i == 0) err_first = err_illegal;
            if (err_illegal) errs++;
            if (arb_req) reqs++;
            if (dbg_state !== 3'd0 || done) busy++;
        end
        tests++;
        if (err_first !== 1'b1 || errs != 1) begin
            fails++; $display("FAIL illegal_err: first %0b pulses %0d expected 1/1", err_first, errs);
        end
        tests++;
        if (reqs != 0 || busy != 0) begin
            fails++; $display("FAIL illegal_idle: reqs %0d non-idle %0d expected 0/0", reqs, busy);
        end
    endtask

    task automatic test_reset_mid_load();
        int nd; bit to;
        gnt_mode = 3; gnt_budget = 3; lat = 20;
        for (int i = 0; i < N; i++) begin
            stage[i] = {$urandom, $urandom};
            ext_mem[48'h50000 + 48'(i * 8)] = stage[i];
        end
        issue(OP_LOAD, 3'd2, 3'd0, 3'd0, 48'h50000);
        repeat (5) @(negedge clk);
        tests++;
        if (inflight != 3) begin
            fails++; $display("FAIL rst_inflight: got %0d expected 3", inflight);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stall_cnt = 0;
        tests++;
        if (arb_req !== 1'b0 || dbg_state !== 3'd0 || done !== 1'b0) begin
            fails++; $display("FAIL rst_mid: req %0b state %0d done %0b expected 0/0/0", arb_req,
                              dbg_state, done);
        end
        repeat (30) @(negedge clk);
        gnt_mode = 0; lat = 3;
        check_slots(3'd2, 3'd4, 3'd0, "rst_untouched");
        load_stage(3'd2, 48'h50000, nd, to);
        tests++;
        if (to !== 1'b0 || nd != 1) begin
            fails++; $display("FAIL rst_reload: done %0d timeout %0d expected 1/0", nd, to);
        end
        check_slots(3'd2, 3'd1, 3'd3, "rst_reload");
        tests++;
        if (perf_counter_out !== exp_perf()) begin
            fails++; $display("FAIL perf_final: got %0d expected %0d", perf_counter_out, exp_perf());
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_elem();
        test_random_elem();
        test_illegal();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
